// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store unit:
// op encodings, FSM state encoding and alignment helpers.
package dm_pkg;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    function automatic logic is_load(input logic [2:0] op);
        return (op <= OP_LBU);
    endfunction

    // Byte ops can never be misaligned; halfwords need bit 0 clear, words both bits.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic mis;
        case (op)
            OP_LW, OP_SW:          mis = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH:  mis = off[0];
            default:               mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Combinational byte-lane logic: extract+extend for loads, lane merge for stores.
// Little-endian lanes: offset 0 is bits 7:0.
module dm_lane
    import dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] sdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[7:0];
        case (off_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_o = word_i;
        case (op_i)
            OP_LH:   load_o = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_o = {16'h0000, half_v};
            OP_LB:   load_o = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_o = {24'h000000, byte_v};
            default: load_o = word_i;
        endcase
    end

    // SW passes store data straight through so the top can always use merged_o.
    always_comb begin
        merged_o = word_i;
        case (op_i)
            OP_SW: merged_o = sdata_i;
            OP_SH: begin
                if (off_i[1]) merged_o[31:16] = sdata_i[15:0];
                else          merged_o[15:0]  = sdata_i[15:0];
            end
            OP_SB: begin
                case (off_i)
                    2'd0:    merged_o[7:0]   = sdata_i[7:0];
                    2'd1:    merged_o[15:8]  = sdata_i[7:0];
                    2'd2:    merged_o[23:16] = sdata_i[7:0];
                    default: merged_o[31:24] = sdata_i[7:0];
                endcase
            end
            default: merged_o = word_i;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit in front of a 1024x32 data memory: sub-word loads/stores,
// read-modify-write for SH/SB, misalignment detection, req/done handshake.
module dm_lsu
    import dm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    state_t      state_q;
    logic [2:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] lane_word;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr[31:12];

    assign lane_word = (state_q == ST_LOAD) ? mem_rdata : merge_q;

    dm_lane u_lane (
        .word_i   (lane_word),
        .off_i    (addr_q[1:0]),
        .op_i     (op_q),
        .sdata_i  (wdata_q),
        .load_o   (lane_load),
        .merged_o (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        op_q    <= op;
                        addr_q  <= addr[11:0];
                        wdata_q <= wdata;
                        err_q   <= is_misaligned(op, addr[1:0]);
                        if (is_misaligned(op, addr[1:0])) state_q <= ST_RESP;
                        else if (is_load(op))             state_q <= ST_LOAD;
                        else if (op == OP_SW)             state_q <= ST_WRITE;
                        else                              state_q <= ST_RMW_RD;
                    end
                end
                ST_LOAD: begin
                    rdata_q <= lane_load;
                    state_q <= ST_RESP;
                end
                ST_RMW_RD: begin
                    merge_q <= mem_rdata;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: state_q <= ST_RESP;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_RESP);
    assign err       = (state_q == ST_RESP) && err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q[11:2];
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_wdata = (state_q == ST_WRITE) ? lane_merged : '0;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed self-checking bench for dm_lsu with a behavioural 1024x32 memory
// that reads combinationally and writes on the falling edge.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) mem[mem_addr] = mem_wdata;
    assign mem_rdata = mem[mem_addr];

    dm_lsu dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    // Issues one access and watches 8 cycles; cycle 0 is the request cycle.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_cyc, input logic exp_err,
                          input int exp_we, input logic [31:0] exp_rdata);
        int done_cyc, done_cnt, we_cnt, we_cyc;
        logic err_s;
        logic [9:0]  we_addr;
        logic [31:0] rd_s;
        done_cyc = -1; done_cnt = 0; we_cnt = 0; we_cyc = -1; err_s = 1'b0;
        we_addr = '0; rd_s = '0;
        @(posedge clk); #1;
        req = 1'b1; op = o; addr = a; wdata = wd;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = k; err_s = err; rd_s = rdata; end
            end
            if (mem_we) begin we_cnt++; we_cyc = k; we_addr = mem_addr; end
            @(posedge clk); #1;
            req = 1'b0;
        end
        checks++;
        if (done_cyc !== exp_cyc || done_cnt !== 1) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d (count %0d) expected %0d (count 1)", name, done_cyc, done_cnt, exp_cyc);
        end
        checks++;
        if (err_s !== exp_err) begin
            failures++;
            $display("FAIL %s err: got %b expected %b", name, err_s, exp_err);
        end
        checks++;
        if (we_cnt !== exp_we) begin
            failures++;
            $display("FAIL %s mem_we_cycles: got %0d expected %0d", name, we_cnt, exp_we);
        end
        if (exp_we == 1) begin
            checks++;
            if (we_cyc !== exp_cyc - 1 || we_addr !== a[11:2]) begin
                failures++;
                $display("FAIL %s write_slot: cycle %0d addr %h expected cycle %0d addr %h", name, we_cyc, we_addr, exp_cyc - 1, a[11:2]);
            end
        end
        checks++;
        if (rd_s !== exp_rdata || rdata !== exp_rdata) begin
            failures++;
            $display("FAIL %s rdata: at done %h after %h expected %h", name, rd_s, rdata, exp_rdata);
        end
    endtask

    task automatic check_mem(input string name, input int idx, input logic [31:0] exp);
        checks++;
        if (mem[idx] !== exp) begin
            failures++;
            $display("FAIL %s mem[%0d]: got %h expected %h", name, idx, mem[idx], exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({busy, done, err, mem_we} !== 4'b0000 || rdata !== 32'h0 ||
            mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL %s reset_outputs: busy %b done %b err %b we %b rdata %h maddr %h mwdata %h expected all zero",
                     name, busy, done, err, mem_we, rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic test_load_ext();
        mem[4] = 32'h8070_F0A5;
        run_op("lb_0x13",  3'b011, 32'h0000_0013, 32'h0, 2, 1'b0, 0, 32'hFFFF_FF80);
        run_op("lbu_0x12", 3'b100, 32'h0000_0012, 32'h0, 2, 1'b0, 0, 32'h0000_0070);
        run_op("lh_0x10",  3'b001, 32'hFFFF_F010, 32'h0, 2, 1'b0, 0, 32'hFFFF_F0A5);
        run_op("lhu_0x12", 3'b010, 32'h0000_0012, 32'h0, 2, 1'b0, 0, 32'h0000_8070);
    endtask

    task automatic test_sw_lw();
        mem[255] = 32'h0;
        run_op("sw_0x3fc", 3'b101, 32'h0000_03FC, 32'hDEAD_BEEF, 2, 1'b0, 1, 32'h0000_8070);
        check_mem("sw_0x3fc", 255, 32'hDEAD_BEEF);
        run_op("lw_0x3fc", 3'b000, 32'h0000_03FC, 32'h0, 2, 1'b0, 0, 32'hDEAD_BEEF);
    endtask

    task automatic test_rmw();
        mem[8] = 32'h1122_3344;
        run_op("sb_0x21", 3'b111, 32'h0000_0021, 32'hFFFF_FFAB, 3, 1'b0, 1, 32'hDEAD_BEEF);
        check_mem("sb_0x21", 8, 32'h1122_AB44);
        run_op("sh_0x22", 3'b110, 32'h0000_0022, 32'h1234_CAFE, 3, 1'b0, 1, 32'hDEAD_BEEF);
        check_mem("sh_0x22", 8, 32'hCAFE_AB44);
    endtask

    task automatic test_misaligned();
        mem[0] = 32'h0102_0304;
        mem[1] = 32'h0506_0708;
        run_op("lw_0x002", 3'b000, 32'h0000_0002, 32'h0, 1, 1'b1, 0, 32'hDEAD_BEEF);
        run_op("sh_0x005", 3'b110, 32'h0000_0005, 32'h0000_9999, 1, 1'b1, 0, 32'hDEAD_BEEF);
        check_mem("mis_w0", 0, 32'h0102_0304);
        check_mem("mis_w1", 1, 32'h0506_0708);
    endtask

    // req held high across three LWs; acceptance = req seen while not busy.
    task automatic test_back_to_back();
        logic [31:0] vals [3];
        int acc [3];
        logic [31:0] rd [3];
        int n, d;
        vals[0] = 32'hA0A0_0001; vals[1] = 32'hB0B0_0002; vals[2] = 32'hC0C0_0003;
        mem[16] = vals[0]; mem[17] = vals[1]; mem[18] = vals[2];
        n = 0; d = 0;
        for (int i = 0; i < 3; i++) begin acc[i] = -1; rd[i] = '0; end
        @(posedge clk); #1;
        req = 1'b1; op = 3'b000; addr = 32'h40;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done) begin if (d < 3) rd[d] = rdata; d++; end
            if (!busy && req && n < 3) begin acc[n] = k; n++; end
            @(posedge clk); #1;
            if (n >= 3) req = 1'b0;
            else addr = 32'h40 + 32'(4 * n);
        end
        req = 1'b0;
        checks++;
        if (acc[0] !== 0 || acc[1] !== 3 || acc[2] !== 6) begin
            failures++;
            $display("FAIL b2b acceptance_cycles: got %0d %0d %0d expected 0 3 6", acc[0], acc[1], acc[2]);
        end
        checks++;
        if (d !== 3) begin
            failures++;
            $display("FAIL b2b done_count: got %0d expected 3", d);
        end
        checks++;
        if (rd[0] !== vals[0] || rd[1] !== vals[1] || rd[2] !== vals[2]) begin
            failures++;
            $display("FAIL b2b rdata: got %h %h %h expected %h %h %h", rd[0], rd[1], rd[2], vals[0], vals[1], vals[2]);
        end
    endtask

    // SB then an LW request raised while busy; it must wait for IDLE (cycle 4).
    task automatic test_req_while_busy();
        int acc [2];
        int n, d;
        logic [31:0] rd2;
        mem[20] = 32'h1111_1111;
        n = 0; d = 0; rd2 = '0; acc[0] = -1; acc[1] = -1;
        @(posedge clk); #1;
        req = 1'b1; op = 3'b111; addr = 32'h50; wdata = 32'h55;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) begin d++; if (d == 2) rd2 = rdata; end
            if (!busy && req && n < 2) begin acc[n] = k; n++; end
            @(posedge clk); #1;
            if (n == 1) begin op = 3'b000; addr = 32'h50; end
            if (n >= 2) req = 1'b0;
        end
        req = 1'b0;
        checks++;
        if (acc[0] !== 0 || acc[1] !== 4) begin
            failures++;
            $display("FAIL busy_req acceptance_cycles: got %0d %0d expected 0 4", acc[0], acc[1]);
        end
        checks++;
        if (d !== 2 || rd2 !== 32'h1111_1155) begin
            failures++;
            $display("FAIL busy_req result: dones %0d rdata %h expected 2 and 11111155", d, rd2);
        end
    endtask

    task automatic test_reset_rmw();
        int dn, we;
        mem[24] = 32'h5566_7788;
        dn = 0; we = 0;
        @(posedge clk); #1;
        req = 1'b1; op = 3'b111; addr = 32'h60; wdata = 32'hEE;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        if (done) dn++;
        if (mem_we) we++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) dn++;
            if (mem_we) we++;
        end
        checks++;
        if (dn !== 0 || we !== 0) begin
            failures++;
            $display("FAIL rst_rmw activity: dones %0d writes %0d expected 0 0", dn, we);
        end
        check_mem("rst_rmw", 24, 32'h5566_7788);
        check_idle_outputs("rst_rmw");
    endtask

    task automatic test_reset_write();
        int dn;
        logic we_seen;
        mem[28] = 32'h0;
        dn = 0; we_seen = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; op = 3'b101; addr = 32'h70; wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        we_seen = mem_we;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (we_seen !== 1'b1) begin
            failures++;
            $display("FAIL rst_write we_in_write: got %b expected 1", we_seen);
        end
        check_mem("rst_write", 28, 32'h0BAD_F00D);
        check_idle_outputs("rst_write");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn !== 0) begin
            failures++;
            $display("FAIL rst_write done_after_reset: got %0d expected 0", dn);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_load_ext();
        test_sw_lw();
        test_rmw();
        test_misaligned();
        test_back_to_back();
        test_req_while_busy();
        test_reset_rmw();
        test_reset_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
